// File: rtl/booth_datapath.sv
// -----------------------------------------------------------------------------
// booth_datapath
//
// Radix-2 Booth signed-multiplier datapath for the 8-bit ALU. The ALU control
// unit drives one-hot micro-operation strobes. This block holds the operand and
// partial-product registers and reports the status bits the controller branches
// on.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset (clears every register)
//   multiplicand        signed operand M, captured on booth_load
//   multiplier          signed operand Q, captured on booth_load
//   booth_load          initialise all registers from the operands
//   booth_add_en        A <= A + M
//   booth_sub_en        A <= A - M (wins over booth_add_en)
//   booth_shift_en      arithmetic right shift of {A,Q,Q_1}; dropped when
//                       add or sub is active in the same cycle
//   booth_count_en      decrement the iteration counter, saturating at zero
//   booth_bits          {Q[0], Q_1}, the Booth recoding pair
//   booth_counter_done  high while the iteration counter is zero
//   product             {A[WIDTH-1:0], Q}, the signed 2*WIDTH-bit product
//   product_valid       registered; set by the count strobe that finds the
//                       counter already at zero
// -----------------------------------------------------------------------------
module booth_datapath #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic                 booth_load,
   input  logic                 booth_add_en,
   input  logic                 booth_sub_en,
   input  logic                 booth_shift_en,
   input  logic                 booth_count_en,
   output logic [1:0]           booth_bits,
   output logic                 booth_counter_done,
   output logic [2*WIDTH-1:0]   product,
   output logic                 product_valid
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH:0]   EXT_ZERO = {(WIDTH+1){1'b0}};
   localparam logic [WIDTH-1:0] OP_ZERO  = {WIDTH{1'b0}};

   // M and A carry one guard bit. This lets A - M stay representable when
   // M = -2^(WIDTH-1).
   logic [WIDTH:0]     m_r;
   logic [WIDTH:0]     a_r;
   logic [WIDTH-1:0]   q_r;
   logic               q1_r;
   logic [CNT_W-1:0]   count_r;
   logic               valid_r;

   logic [WIDTH:0]     m_s;
   logic [WIDTH:0]     a_s;
   logic [WIDTH-1:0]   q_s;
   logic               q1_s;
   logic [CNT_W-1:0]   count_s;
   logic               valid_s;

   // Next-state logic. Priority: load, then sub, then add, then shift. The
   // counter path runs independently of the arithmetic path.
   always_comb begin
      m_s     = m_r;
      a_s     = a_r;
      q_s     = q_r;
      q1_s    = q1_r;
      count_s = count_r;
      valid_s = valid_r;

      if (booth_load) begin
         m_s     = {multiplicand[WIDTH-1], multiplicand};
         a_s     = EXT_ZERO;
         q_s     = multiplier;
         q1_s    = 1'b0;
         count_s = CNT_INIT;
         valid_s = 1'b0;
      end else begin
         if (booth_sub_en) begin
            a_s = a_r - m_r;
         end else if (booth_add_en) begin
            a_s = a_r + m_r;
         end else if (booth_shift_en) begin
            // The sign of A is replicated, and the old Q_1 falls off the end.
            {a_s, q_s, q1_s} = {a_r[WIDTH], a_r, q_r};
         end else begin
            a_s = a_r;
         end

         if (booth_count_en) begin
            if (count_r != CNT_ZERO) begin
               count_s = count_r - CNT_ONE;
            end else begin
               // The counter saturates at zero. The count that finds it there
               // closes the multiply.
               valid_s = 1'b1;
            end
         end else begin
            count_s = count_r;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_r     <= EXT_ZERO;
         a_r     <= EXT_ZERO;
         q_r     <= OP_ZERO;
         q1_r    <= 1'b0;
         count_r <= CNT_ZERO;
         valid_r <= 1'b0;
      end else begin
         m_r     <= m_s;
         a_r     <= a_s;
         q_r     <= q_s;
         q1_r    <= q1_s;
         count_r <= count_s;
         valid_r <= valid_s;
      end
   end

   // Status and product views decoded directly from the registers.
   always_comb begin
      booth_bits         = {q_r[0], q1_r};
      booth_counter_done = (count_r == CNT_ZERO);
      product            = {a_r[WIDTH-1:0], q_r};
      product_valid      = valid_r;
   end

endmodule

// File: tb/tb_booth_datapath.sv
// -----------------------------------------------------------------------------
// tb_booth_datapath
//
// Self-checking bench for booth_datapath. It plays the role of the ALU
// controller, driving the Booth strobe sequence from booth_bits. A behavioural
// model keeps the abstract state: iteration count, valid flag, and the
// arithmetic product captured at load. A compare process checks the DUT
// against the model on every negative edge.
// -----------------------------------------------------------------------------
module tb_booth_datapath;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic [WIDTH-1:0]    multiplicand;
   logic [WIDTH-1:0]    multiplier;
   logic                booth_load;
   logic                booth_add_en;
   logic                booth_sub_en;
   logic                booth_shift_en;
   logic                booth_count_en;
   logic [1:0]          booth_bits;
   logic                booth_counter_done;
   logic [2*WIDTH-1:0]  product;
   logic                product_valid;

   booth_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk                (clk),
      .reset              (reset),
      .multiplicand       (multiplicand),
      .multiplier         (multiplier),
      .booth_load         (booth_load),
      .booth_add_en       (booth_add_en),
      .booth_sub_en       (booth_sub_en),
      .booth_shift_en     (booth_shift_en),
      .booth_count_en     (booth_count_en),
      .booth_bits         (booth_bits),
      .booth_counter_done (booth_counter_done),
      .product            (product),
      .product_valid      (product_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model: the abstract counter value, the valid flag, and the
   // true signed product of the operands captured at load.
   int           mdl_cnt   = 0;
   bit           mdl_valid = 1'b0;
   bit           mdl_rst   = 1'b0;
   bit           started   = 1'b0;
   bit           prod_chk  = 1'b0;
   logic [15:0]  mdl_prod  = 16'h0000;

   function automatic logic [15:0] signed_mul(input logic [7:0] a, input logic [7:0] b);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      return 16'(sa * sb);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         mdl_cnt   = 0;
         mdl_valid = 1'b0;
         mdl_rst   = 1'b1;
         started   = 1'b1;
      end else if (booth_load) begin
         mdl_cnt   = WIDTH - 1;
         mdl_valid = 1'b0;
         mdl_rst   = 1'b0;
         mdl_prod  = signed_mul(multiplicand, multiplier);
      end else if (booth_count_en) begin
         if (mdl_cnt > 0) mdl_cnt = mdl_cnt - 1;
         else mdl_valid = 1'b1;
      end
   end

   // Compare process: checks the DUT against the model every cycle, away from
   // the active clock edge.
   always @(negedge clk) begin
      if (started) begin
         check("cyc_done", 32'(booth_counter_done), 32'(mdl_cnt == 0));
         check("cyc_valid", 32'(product_valid), 32'(mdl_valid));
         if (mdl_rst) begin
            check("cyc_rst_product", 32'(product), 32'd0);
            check("cyc_rst_bits", 32'(booth_bits), 32'd0);
         end
         if (mdl_valid && prod_chk) begin
            check("cyc_product", 32'(product), 32'(mdl_prod));
         end
      end
   end

   // Acts as the controller for one multiply: LOAD, then up to max_it
   // iterations of CHECK, optional ADD/SUB, SHIFT and COUNT. Operand inputs are
   // scrambled after load to show they are ignored.
   task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input int max_it,
                          input bit full, output int shifts);
      logic [1:0] bits;
      logic       d;
      shifts = 0;
      d      = 1'b0;
      prod_chk = 1'b0;
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      booth_load   = 1'b1;
      @(negedge clk);
      booth_load = 1'b0;
      prod_chk   = full;
      for (int it = 0; it < max_it; it++) begin
         multiplicand = 8'($urandom);
         multiplier   = 8'($urandom);
         bits = booth_bits;
         @(negedge clk);
         if (bits == 2'b10) begin
            booth_sub_en = 1'b1;
            @(negedge clk);
            booth_sub_en = 1'b0;
         end else if (bits == 2'b01) begin
            booth_add_en = 1'b1;
            @(negedge clk);
            booth_add_en = 1'b0;
         end
         booth_shift_en = 1'b1;
         @(negedge clk);
         booth_shift_en = 1'b0;
         shifts++;
         d = booth_counter_done;
         booth_count_en = 1'b1;
         @(negedge clk);
         booth_count_en = 1'b0;
         if (d) break;
      end
      if (full) check("done_reached", 32'(d), 32'd1);
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;

   vec_t vecs[5];
   int   sh;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset          = 1'b0;
      multiplicand   = 8'h00;
      multiplier     = 8'h00;
      booth_load     = 1'b0;
      booth_add_en   = 1'b0;
      booth_sub_en   = 1'b0;
      booth_shift_en = 1'b0;
      booth_count_en = 1'b0;

      // Reset held for two cycles while the strobes are random.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         reset = 1'b1;
         {booth_load, booth_add_en, booth_sub_en, booth_shift_en, booth_count_en} = 5'($urandom);
         multiplicand = 8'($urandom);
         multiplier   = 8'($urandom);
      end
      @(negedge clk);
      reset = 1'b0;
      {booth_load, booth_add_en, booth_sub_en, booth_shift_en, booth_count_en} = 5'b00000;
      check("rst_bits", 32'(booth_bits), 32'd0);
      check("rst_done", 32'(booth_counter_done), 32'd1);
      check("rst_product", 32'(product), 32'h0000);
      check("rst_valid", 32'(product_valid), 32'd0);

      // Directed products, including the corner case that exercises the guard bit.
      vecs[0] = '{8'd3,   8'd5,   16'h000F};
      vecs[1] = '{8'hFD,  8'd5,   16'hFFF1};
      vecs[2] = '{8'd127, 8'h80,  16'hC080};
      vecs[3] = '{8'd0,   8'hB3,  16'h0000};
      vecs[4] = '{8'h80,  8'h80,  16'h4000};
      foreach (vecs[i]) begin
         run_mul(vecs[i].a, vecs[i].b, 16, 1'b1, sh);
         check($sformatf("dir%0d_product", i), 32'(product), 32'(vecs[i].p));
         check($sformatf("dir%0d_model", i), 32'(mdl_prod), 32'(vecs[i].p));
         check($sformatf("dir%0d_valid", i), 32'(product_valid), 32'd1);
         check($sformatf("dir%0d_shifts", i), 32'(sh), 32'd8);
      end

      // Counter boundary: done rises after 7 counts, valid after 8, and there is no wrap.
      prod_chk = 1'b0;
      @(negedge clk);
      multiplicand = 8'h21;
      multiplier   = 8'h5A;
      booth_load   = 1'b1;
      @(negedge clk);
      booth_load = 1'b0;
      check("cnt_done_start", 32'(booth_counter_done), 32'd0);
      for (int i = 1; i <= 9; i++) begin
         booth_count_en = 1'b1;
         @(negedge clk);
         booth_count_en = 1'b0;
         check($sformatf("cnt%0d_done", i), 32'(booth_counter_done), 32'(i >= 7));
         check($sformatf("cnt%0d_valid", i), 32'(product_valid), 32'(i >= 8));
      end
      check("cnt_product_untouched", 32'(product), 32'h005A);

      // Reset in the middle of a multiply, followed by a clean reload.
      run_mul(8'd3, 8'd5, 3, 1'b0, sh);
      check("mid_shifts", 32'(sh), 32'd3);
      @(negedge clk);
      reset = 1'b1;
      booth_shift_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      booth_shift_en = 1'b0;
      check("mid_rst_product", 32'(product), 32'h0000);
      check("mid_rst_bits", 32'(booth_bits), 32'd0);
      check("mid_rst_done", 32'(booth_counter_done), 32'd1);
      check("mid_rst_valid", 32'(product_valid), 32'd0);
      run_mul(8'd6, 8'd7, 16, 1'b1, sh);
      check("reload_product", 32'(product), 32'h002A);
      check("reload_shifts", 32'(sh), 32'd8);

      // Strobe priority checks, starting from M=3 and Q=5.
      prod_chk = 1'b0;
      @(negedge clk);
      multiplicand   = 8'd3;
      multiplier     = 8'd5;
      booth_load     = 1'b1;
      booth_shift_en = 1'b1;
      @(negedge clk);
      booth_load = 1'b0;
      check("pri_load_product", 32'(product), 32'h0005);
      check("pri_load_bits", 32'(booth_bits), 32'd2);
      check("pri_load_done", 32'(booth_counter_done), 32'd0);
      booth_add_en = 1'b1;
      @(negedge clk);
      booth_shift_en = 1'b0;
      check("pri_add_product", 32'(product), 32'h0305);
      booth_sub_en = 1'b1;
      @(negedge clk);
      booth_add_en = 1'b0;
      booth_sub_en = 1'b0;
      check("pri_sub_product", 32'(product), 32'h0005);
      booth_shift_en = 1'b1;
      @(negedge clk);
      booth_shift_en = 1'b0;
      check("pri_shift_product", 32'(product), 32'h0002);
      check("pri_shift_bits", 32'(booth_bits), 32'd1);
      @(negedge clk);
      check("idle_hold", 32'(product), 32'h0002);

      // Random operand pairs checked against plain signed multiplication.
      for (int i = 0; i < 24; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ((i % 8) == 3) ra = 8'h80;
         if ((i % 8) == 5) rb = 8'h80;
         if ((i % 8) == 6) rb = 8'h7F;
         run_mul(ra, rb, 16, 1'b1, sh);
         check($sformatf("rnd%0d_product(%0h*%0h)", i, ra, rb), 32'(product), 32'(signed_mul(ra, rb)));
         check($sformatf("rnd%0d_shifts", i), 32'(sh), 32'd8);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/booth_datapath.md
Name: booth_datapath

Overview:
- Radix-2 Booth signed-multiplier datapath for the 8-bit ALU. It sits directly downstream of the ALU control unit.
- It consumes the one-hot micro-operation strobes (booth_load, booth_add_en, booth_sub_en, booth_shift_en, booth_count_en).
- It returns the status the controller branches on: booth_bits and booth_counter_done.
- It holds multiplicand, accumulator, multiplier/product and iteration counter, and presents the signed 2*WIDTH-bit product.

Parameters:
- WIDTH, 8, operand width in bits (two's complement).
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- multiplicand  input  WIDTH  signed operand M, sampled on booth_load.
- multiplier  input  WIDTH  signed operand Q, sampled on booth_load.
- booth_load  input  1  initialise all registers from operands.
- booth_add_en  input  1  A <= A + M.
- booth_sub_en  input  1  A <= A - M.
- booth_shift_en  input  1  arithmetic right shift of {A,Q,Q_1}.
- booth_count_en  input  1  decrement iteration counter.
- booth_bits  output  2  {Q[0], Q_1}, combinational from registers.
- booth_counter_done  output  1  (count == 0), combinational.
- product  output  2*WIDTH  {A[WIDTH-1:0], Q}, combinational from registers.
- product_valid  output  1  registered; high once the final iteration has been counted.

Behaviour:
- Registers:
  - M: WIDTH+1 bits, sign-extended.
  - A: WIDTH+1 bits. The guard bit prevents overflow for M = -2^(WIDTH-1).
  - Q: WIDTH bits.
  - Q_1: 1 bit.
  - count: CNT_W bits.
  - product_valid: 1 bit.
- Reset (synchronous; overrides every strobe): all registers 0. Consequently:
  - booth_bits = 00
  - booth_counter_done = 1
  - product = 0
  - product_valid = 0
- booth_load (highest priority after reset):
  - M <= sext(multiplicand); Q <= multiplier; A <= 0; Q_1 <= 0.
  - count <= WIDTH-1; product_valid <= 0.
  - All other strobes are ignored in that cycle.
- booth_add_en / booth_sub_en:
  - A <= A ± M, modulo 2^(WIDTH+1). Q and Q_1 are unchanged.
  - If both are asserted together, booth_sub_en wins. This is a protocol error; the controller never does it.
- booth_shift_en: {A,Q,Q_1} <= {A[WIDTH], A, Q} >> 1, arithmetic (A's sign bit replicated).
  - Applied only when neither add nor sub is active in the same cycle. If asserted together, add/sub wins and the shift is dropped.
- booth_count_en (independent of add/sub/shift, overridden by load):
  - If count != 0: count <= count-1.
  - If count == 0: count holds at 0 (no wrap) and product_valid <= 1.
- Counter semantics: the controller samples booth_counter_done in its COUNT state, before the decrement lands.
  - Iteration k sees count = WIDTH-k.
  - Done is therefore seen exactly on iteration WIDTH, giving exactly WIDTH shift iterations per multiply.
- Controller sequence per multiply:
  - LOAD
  - WIDTH × (CHECK, optional ADD/SUB, SHIFT, COUNT)
  - DONE
- Latency, in cycles:
  - 1 for the load.
  - Per iteration: 3 for CHECK, SHIFT and COUNT, plus 1 if an ADD or SUB is taken. Iterations never exceed 4 cycles.
  - product_valid rises the cycle after the final COUNT.
- product validity: exact signed product for all operand pairs including -2^(WIDTH-1) × -2^(WIDTH-1); meaningful only while product_valid = 1.
- Operand change: operand inputs are not sampled outside booth_load, so changing them mid-operation has no effect.
- Reset mid-operation: returns to the reset values above on the next edge. The subsequent booth_load starts a clean multiply.
- Back-to-back multiply: booth_load while product_valid = 1 clears product_valid and restarts.
- Idle state: registers hold when no strobe is active.

Test Plan:
- Reset: reset=1 for 2 cycles with random strobes -> booth_bits=00, booth_counter_done=1, product=0x0000, product_valid=0.
- Positive × positive: multiplicand=3, multiplier=5, bench drives the controller sequence from booth_bits -> product=0x000F, product_valid=1, exactly 8 shifts observed.
- Mixed signs:
  - -3 × 5 -> 0xFFF1.
  - 127 × -128 -> 0xC080.
  - 0 × -77 -> 0x0000.
- Corner case: -128 × -128 -> 0x4000. This checks the A guard bit during an A - M with M = -128.
- Counter boundary: after load, pulse booth_count_en 7 times -> booth_counter_done=0 until count 0, then 1. An 8th pulse sets product_valid=1. A 9th pulse leaves count at 0, with no wrap.
- Reset mid-multiply plus priority:
  - Assert reset after 3 iterations of 3×5 -> all state cleared. A reload of 6×7 then gives 0x002A.
  - booth_load with booth_shift_en in the same cycle -> load only.
  - add with shift in the same cycle -> add only.
